fft_frame_rx: RTL and testbench
===============================

FFT_FRAME_RX -- requirements
Module: fft_frame_rx

Interface
REQ-001 Parameter N_POINTS, default 1024; frame length in bins, power of two, minimum 8.
REQ-002 Parameter DW, default 12; width of signed real/imag input samples.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 source_valid  input  1  FFT output beat valid.
REQ-007 source_sop  input  1  first bin of frame; qualified by source_valid.
REQ-008 source_eop  input  1  last bin of frame; qualified by source_valid.
REQ-009 source_real  input  DW  signed real part, two's complement.
REQ-010 source_imag  input  DW  signed imaginary part, two's complement.
REQ-011 source_exp  input  6  block exponent; captured on the sop beat.
REQ-012 source_ready  output  1  block accepts a beat; a beat transfers when source_valid and source_ready are both 1.
REQ-013 result_valid  output  1  frame result held; stays high until acknowledged.
REQ-014 result_ack  input  1  consumer takes the result; acts only while result_valid=1.
REQ-015 peak_bin  output  log2(N_POINTS)  index of the largest-power bin.
REQ-016 peak_pow  output  2*DW+1  unsigned power of that bin.
REQ-017 frame_exp  output  6  source_exp captured from the frame.
REQ-018 frame_err  output  1  one-cycle pulse on a framing violation.

Function
REQ-019 The FSM SHALL have states IDLE, RECV and HOLD; IDLE and RECV drive source_ready=1, HOLD drives it to 0.
REQ-020 IDLE: non-sop beats are discarded with no error; a sop beat sets bin index 0, captures source_exp and enters RECV.
REQ-021 RECV: each accepted beat increments the bin index by 1.
REQ-022 Power SHALL be re*re + im*im, computed at full precision into 2*DW+1 bits with no truncation, and registered one cycle after the beat (pipeline stage 1).
REQ-023 Stage 2 SHALL compare the registered power against the running max only for bins 1..N_POINTS/2-1 (DC and the mirror half are excluded); the max updates only on strictly greater, so ties keep the lower bin.
REQ-024 On sop, the running max SHALL be initialised to power 0, bin 1.
REQ-025 eop accepted at index N_POINTS-1: enter HOLD; result_valid SHALL rise 2 cycles after the eop edge, with peak_bin/peak_pow/frame_exp final and stable through HOLD.
REQ-026 Error, eop at index < N_POINTS-1: frame_err pulse, no result, return to IDLE.
REQ-027 Error, index N_POINTS-1 accepted without eop: frame_err pulse, no result, return to IDLE.
REQ-028 Error, sop in RECV: frame_err pulse, that beat restarts a new frame at index 0 (REQ-020, REQ-024).
REQ-029 A beat carrying both sop and eop is an error under REQ-026 when N_POINTS>1.
REQ-030 HOLD: result_ack=1 SHALL clear result_valid on the next edge and return to IDLE; source_ready rises on that same edge.
REQ-031 Pipeline stages 1-2 SHALL drain independently of source_valid gaps; idle cycles do not alter the index or the running max.
REQ-032 Outputs peak_bin, peak_pow and frame_exp SHALL be registered and hold their last result outside HOLD.

Reset
REQ-033 With rst_n=0: state IDLE, source_ready=1, result_valid=0, frame_err=0, peak_bin=0, peak_pow=0, frame_exp=0, index and pipelines cleared.
REQ-034 Reset asserted mid-frame or in HOLD SHALL abandon the frame immediately with no result and no error pulse.

Verification (N_POINTS=16, DW=12)
REQ-035 16 contiguous beats, bin 5 re=100 im=-50, all others 0 -> result_valid 2 cycles after eop, peak_bin=5, peak_pow=12500.
REQ-036 All bins re=im=0, bin 0 re=2047 -> DC ignored, peak_bin=1, peak_pow=0.
REQ-037 Bins 3 and 6 both re=-2048 im=-2048 -> peak_bin=3, peak_pow=8388608 (no overflow).
REQ-038 eop at index 9 -> single frame_err pulse, result_valid stays 0; next clean frame is reported correctly.
REQ-039 sop at index 7 of a frame -> frame_err pulse; the new frame completes 16 beats later with a correct result.
REQ-040 Result held with result_ack=0 for 20 cycles -> source_ready=0 and outputs stable; ack -> result_valid=0 and source_ready=1 on the next edge.

Source files
------------

// File: rtl/fft_frame_rx.sv
// Receives one FFT output frame, finds the strongest positive-frequency bin
// (bins 1..N/2-1) and holds that result until the consumer acknowledges it.
module fft_frame_rx #(
  parameter int N_POINTS = 1024,
  parameter int DW       = 12,
  localparam int IW      = $clog2(N_POINTS),
  localparam int PW      = 2*DW + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 source_valid,
  input  logic                 source_sop,
  input  logic                 source_eop,
  input  logic signed [DW-1:0] source_real,
  input  logic signed [DW-1:0] source_imag,
  input  logic [5:0]           source_exp,
  output logic                 source_ready,
  output logic                 result_valid,
  input  logic                 result_ack,
  output logic [IW-1:0]        peak_bin,
  output logic [PW-1:0]        peak_pow,
  output logic [5:0]           frame_exp,
  output logic                 frame_err,
  output logic [1:0]           fsm_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1, HOLD = 2'd2} state_t;

  state_t state, state_d;
  logic   err_d, done_d;

  // Handshake: a beat transfers on a rising edge where source_valid and
  // source_ready are both 1; source_ready depends only on the FSM state.
  logic          accept, in_frame, last_bin;
  logic [IW-1:0] idx, beat_idx;

  assign source_ready = (state != HOLD);
  assign fsm_state    = state;
  assign accept       = source_valid && source_ready;
  // Outside a frame only a sop beat matters; everything else is dropped.
  assign in_frame     = accept && (source_sop || state == RECV);
  assign beat_idx     = source_sop ? '0 : idx;
  assign last_bin     = (beat_idx == IW'(N_POINTS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    err_d   = 1'b0;
    done_d  = 1'b0;
    case (state)
      IDLE, RECV: begin
        if (in_frame) begin
          if (source_sop && state == RECV) err_d = 1'b1;
          if (source_eop) begin
            if (last_bin) begin
              state_d = HOLD;
              done_d  = 1'b1;
            end else begin
              err_d   = 1'b1;
              state_d = IDLE;
            end
          end else if (last_bin) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = RECV;
          end
        end
      end
      HOLD: if (result_valid && result_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bin index of the next expected beat and the frame's block exponent.
  logic [5:0] exp_cap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      exp_cap   <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= err_d;
      if (in_frame) idx <= beat_idx + IW'(1);
      if (in_frame && source_sop) exp_cap <= source_exp;
    end
  end

  // Squares are non-negative and fit 2*DW bits even for the most negative input.
  logic signed [2*DW-1:0] re_x, im_x, re_sq, im_sq;
  logic [PW-1:0]          pow;

  assign re_x  = (2*DW)'(source_real);
  assign im_x  = (2*DW)'(source_imag);
  assign re_sq = re_x * re_x;
  assign im_sq = im_x * im_x;
  assign pow   = {1'b0, re_sq} + {1'b0, im_sq};

  // Stage 1: registered power of the accepted beat.
  logic          p1_valid, p1_sop, p1_done;
  logic [IW-1:0] p1_bin;
  logic [PW-1:0] p1_pow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_valid <= 1'b0;
      p1_sop   <= 1'b0;
      p1_done  <= 1'b0;
      p1_bin   <= '0;
      p1_pow   <= '0;
    end else begin
      p1_valid <= in_frame;
      p1_sop   <= in_frame && source_sop;
      p1_done  <= done_d;
      p1_bin   <= beat_idx;
      p1_pow   <= pow;
    end
  end

  // Stage 2: running maximum over bins 1..N/2-1; strict compare keeps the lower bin on ties.
  logic          p2_done, in_range;
  logic [IW-1:0] max_bin;
  logic [PW-1:0] max_pow;

  assign in_range = (p1_bin != '0) && (p1_bin < IW'(N_POINTS / 2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p2_done <= 1'b0;
      max_bin <= '0;
      max_pow <= '0;
    end else begin
      p2_done <= p1_done;
      if (p1_valid) begin
        if (p1_sop) begin
          max_pow <= '0;
          max_bin <= IW'(1);
        end else if (in_range && p1_pow > max_pow) begin
          max_pow <= p1_pow;
          max_bin <= p1_bin;
        end
      end
    end
  end

  // Result registers keep the last reported frame until the next one completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_valid <= 1'b0;
      peak_bin     <= '0;
      peak_pow     <= '0;
      frame_exp    <= '0;
    end else if (p2_done) begin
      result_valid <= 1'b1;
      peak_bin     <= max_bin;
      peak_pow     <= max_pow;
      frame_exp    <= exp_cap;
    end else if (result_valid && result_ack) begin
      result_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_frame_rx.sv
// Directed and randomized frames for fft_frame_rx (N_POINTS=16, DW=12),
// checked against a bin-array reference model of the peak search.
module tb_fft_frame_rx;
  localparam int N  = 16;
  localparam int DW = 12;

  logic                 clk, rst_n;
  logic                 source_valid, source_sop, source_eop;
  logic signed [DW-1:0] source_real, source_imag;
  logic [5:0]           source_exp;
  logic                 source_ready, result_valid, result_ack;
  logic [3:0]           peak_bin;
  logic [2*DW:0]        peak_pow;
  logic [5:0]           frame_exp;
  logic                 frame_err;
  logic [1:0]           fsm_state;

  fft_frame_rx #(.N_POINTS(N), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .source_valid(source_valid), .source_sop(source_sop), .source_eop(source_eop),
    .source_real(source_real), .source_imag(source_imag), .source_exp(source_exp),
    .source_ready(source_ready), .result_valid(result_valid), .result_ack(result_ack),
    .peak_bin(peak_bin), .peak_pow(peak_pow), .frame_exp(frame_exp),
    .frame_err(frame_err), .fsm_state(fsm_state)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int failures = 0;
  int err_cnt = 0;

  always @(negedge clk) if (frame_err === 1'b1) err_cnt++;

  logic signed [DW-1:0] fre[N];
  logic signed [DW-1:0] fim[N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic beat(input logic sop, input logic eop,
                      input logic signed [DW-1:0] re, input logic signed [DW-1:0] im,
                      input logic [5:0] ex);
    @(negedge clk);
    source_valid = 1'b1;
    source_sop   = sop;
    source_eop   = eop;
    source_real  = re;
    source_imag  = im;
    source_exp   = ex;
    @(posedge clk);
    #1;
    source_valid = 1'b0;
    source_sop   = 1'b0;
    source_eop   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_bins();
    for (int i = 0; i < N; i++) begin
      fre[i] = '0;
      fim[i] = '0;
    end
  endtask

  task automatic fill_random(input int rng);
    int v;
    for (int i = 0; i < N; i++) begin
      v = int'($urandom_range(2 * rng)) - rng;
      fre[i] = v[DW-1:0];
      v = int'($urandom_range(2 * rng)) - rng;
      fim[i] = v[DW-1:0];
    end
  endtask

  // Reference model: strongest bin among 1..N/2-1, first one wins on ties.
  task automatic model(output logic [63:0] bin, output logic [63:0] pw);
    longint best_p, p;
    int     best_b;
    best_p = 0;
    best_b = 1;
    for (int b = 1; b < N / 2; b++) begin
      p = longint'(fre[b]) * longint'(fre[b]) + longint'(fim[b]) * longint'(fim[b]);
      if (p > best_p) begin
        best_p = p;
        best_b = b;
      end
    end
    bin = 64'(best_b);
    pw  = 64'(best_p);
  endtask

  task automatic send_frame(input logic [5:0] ex, input int max_gap);
    for (int i = 0; i < N; i++) begin
      if (max_gap > 0) idle(int'($urandom_range(max_gap)));
      beat(i == 0, i == N - 1, fre[i], fim[i], ex);
    end
  endtask

  // Called just after the eop edge: result appears exactly two edges later.
  task automatic check_result(input string tag, input logic [5:0] ex);
    logic [63:0] eb, ep;
    model(eb, ep);
    chk({tag, "_rv_e0"}, 64'(result_valid), 64'd0);
    chk({tag, "_ready_hold"}, 64'(source_ready), 64'd0);
    idle(1);
    chk({tag, "_rv_e1"}, 64'(result_valid), 64'd0);
    idle(1);
    chk({tag, "_rv_e2"}, 64'(result_valid), 64'd1);
    chk({tag, "_bin"}, 64'(peak_bin), eb);
    chk({tag, "_pow"}, 64'(peak_pow), ep);
    chk({tag, "_exp"}, 64'(frame_exp), 64'(ex));
  endtask

  task automatic ack();
    @(negedge clk);
    result_ack = 1'b1;
    @(posedge clk);
    #1;
    result_ack = 1'b0;
    chk("ack_rv", 64'(result_valid), 64'd0);
    chk("ack_ready", 64'(source_ready), 64'd1);
  endtask

  initial begin
    int          e0;
    logic [3:0]  hb;
    logic [24:0] hp;
    logic [5:0]  he;
    logic        stable;
    logic [5:0]  rex;

    rst_n = 1'b0;
    source_valid = 1'b0; source_sop = 1'b0; source_eop = 1'b0;
    source_real = '0; source_imag = '0; source_exp = '0;
    result_ack = 1'b0;
    #3;
    chk("rst_ready", 64'(source_ready), 64'd1);
    chk("rst_rv", 64'(result_valid), 64'd0);
    chk("rst_err", 64'(frame_err), 64'd0);
    chk("rst_bin", 64'(peak_bin), 64'd0);
    chk("rst_pow", 64'(peak_pow), 64'd0);
    chk("rst_exp", 64'(frame_exp), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Single strong bin
    clear_bins();
    fre[5] = 12'sd100; fim[5] = -12'sd50;
    e0 = err_cnt;
    send_frame(6'd7, 0);
    check_result("bin5", 6'd7);
    chk("bin5_pow_const", 64'(peak_pow), 64'd12500);
    ack();

    // DC is ignored
    clear_bins();
    fre[0] = 12'sd2047;
    send_frame(6'd3, 0);
    check_result("dc", 6'd3);
    chk("dc_bin_const", 64'(peak_bin), 64'd1);
    ack();

    // Full-scale tie keeps lower bin, no overflow
    clear_bins();
    fre[3] = -12'sd2048; fim[3] = -12'sd2048;
    fre[6] = -12'sd2048; fim[6] = -12'sd2048;
    send_frame(6'd63, 0);
    check_result("tie", 6'd63);
    chk("tie_pow_const", 64'(peak_pow), 64'd8388608);
    chk("tie_no_err", 64'(err_cnt - e0), 64'd0);

    // Hold with no ack for 20 cycles
    hb = peak_bin; hp = peak_pow; he = frame_exp; stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      idle(1);
      if (source_ready !== 1'b0 || result_valid !== 1'b1 ||
          peak_bin !== hb || peak_pow !== hp || frame_exp !== he) stable = 1'b0;
    end
    chk("hold_stable", 64'(stable), 64'd1);
    ack();
    chk("post_ack_bin", 64'(peak_bin), 64'd3);

    // Early eop at index 9
    e0 = err_cnt;
    for (int i = 0; i < 10; i++) beat(i == 0, i == 9, 12'sd5, 12'sd5, 6'd1);
    idle(3);
    chk("early_eop_err", 64'(err_cnt - e0), 64'd1);
    chk("early_eop_rv", 64'(result_valid), 64'd0);
    chk("early_eop_ready", 64'(source_ready), 64'd1);
    fill_random(2047);
    send_frame(6'd12, 0);
    check_result("after_eop", 6'd12);
    ack();

    // sop at index 7 restarts the frame
    e0 = err_cnt;
    for (int i = 0; i < 7; i++) beat(i == 0, 1'b0, 12'sd2000, 12'sd2000, 6'd9);
    fill_random(300);
    send_frame(6'd21, 0);
    check_result("restart", 6'd21);
    chk("restart_err", 64'(err_cnt - e0), 64'd1);
    ack();

    // Missing eop at index 15
    e0 = err_cnt;
    for (int i = 0; i < N; i++) beat(i == 0, 1'b0, 12'sd1, 12'sd1, 6'd2);
    idle(3);
    chk("no_eop_err", 64'(err_cnt - e0), 64'd1);
    chk("no_eop_rv", 64'(result_valid), 64'd0);

    // Stray non-sop beats in IDLE are dropped silently
    e0 = err_cnt;
    for (int i = 0; i < 3; i++) beat(1'b0, i == 2, 12'sd1000, 12'sd1000, 6'd4);
    idle(2);
    chk("stray_err", 64'(err_cnt - e0), 64'd0);
    chk("stray_rv", 64'(result_valid), 64'd0);

    // Reset mid-frame abandons it silently
    e0 = err_cnt;
    for (int i = 0; i < 5; i++) beat(i == 0, 1'b0, 12'sd9, 12'sd9, 6'd5);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    chk("midrst_rv", 64'(result_valid), 64'd0);
    chk("midrst_ready", 64'(source_ready), 64'd1);
    chk("midrst_pow", 64'(peak_pow), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    chk("midrst_err", 64'(err_cnt - e0), 64'd0);

    // Randomized frames with random gaps and value ranges
    for (int f = 0; f < 10; f++) begin
      fill_random((f % 2 == 0) ? 2047 : 3);
      rex = 6'($urandom_range(63));
      e0 = err_cnt;
      send_frame(rex, (f % 3 == 0) ? 0 : 3);
      check_result($sformatf("rand%0d", f), rex);
      chk($sformatf("rand%0d_err", f), 64'(err_cnt - e0), 64'd0);
      idle(int'($urandom_range(2)));
      ack();
      idle(int'($urandom_range(3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
